// File: rtl/msrv32_addr_gen_unit.sv
// ---------------------------------------------------------------------------
// msrv32_addr_gen_unit
//
// Registered address generator for branch / jump / load-store targets.
// The target is base + immediate, where the base is either the PC or rs1.
// For JALR, bit 0 of the sum is cleared. The result is also checked for
// instruction misalignment. Each result is queued in a small DEPTH-entry
// FIFO with valid/ready handshakes on both sides and a flush.
//
// Ports
//   clk_in          clock, all state updates on the rising edge
//   rst_in          synchronous active-high reset
//   valid_in        request valid
//   ready_out       unit can accept a request this cycle
//   pc_in           program counter base                 [XLEN]
//   rs_1_in         register base                        [XLEN]
//   imm_in          sign-extended immediate              [XLEN]
//   iadder_src_in   1 = base rs_1_in, 0 = base pc_in
//   jalr_in         1 = clear bit 0 of the sum
//   valid_out       head-of-queue result valid
//   ready_in        consumer accepts the head this cycle
//   iadder_out      head result address                  [XLEN]
//   misaligned_out  head result not IALIGN-aligned
//   flush_in        discard all queued and incoming requests
//   count_out       entries currently queued             [$clog2(DEPTH)+1]
// ---------------------------------------------------------------------------
module msrv32_addr_gen_unit #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic [XLEN-1:0]            pc_in,
  input  logic [XLEN-1:0]            rs_1_in,
  input  logic [XLEN-1:0]            imm_in,
  input  logic                       iadder_src_in,
  input  logic                       jalr_in,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [XLEN-1:0]            iadder_out,
  output logic                       misaligned_out,
  input  logic                       flush_in,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int PW = $clog2(DEPTH);   // pointer width
  localparam int CW = PW + 1;          // count width, holds 0..DEPTH
  localparam int AB = $clog2(IALIGN);  // low address bits that must be zero

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            misaligned;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            push;
  logic            pop;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] result;
  entry_t          new_entry;

  // -------------------------------------------------------------------------
  // Target computation. The carry out of the sum is dropped, so the address
  // wraps modulo 2^XLEN. The misalignment flag is taken after the JALR clear,
  // which means a JALR target is never flagged when IALIGN = 2.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default value first.
    // This keeps synthesis from inferring a latch on any path that skips an
    // assignment.
    base   = iadder_src_in ? rs_1_in : pc_in;
    sum    = base + imm_in;
    result = sum;
    if (jalr_in) result[0] = 1'b0;
    new_entry.addr       = result;
    new_entry.misaligned = |result[AB-1:0];
  end

  // Full means refuse a push, even when a pop happens in the same cycle.
  assign ready_out = (count_q < CW'(DEPTH)) && !rst_in;
  assign valid_out = (count_q != '0);
  assign push      = valid_in  && ready_out && !flush_in;
  assign pop       = valid_out && ready_in  && !flush_in;

  // -------------------------------------------------------------------------
  // Queue next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_in) begin
      // Stored data is left in place. It is unreachable once count is zero.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        // DEPTH is a power of two, so the natural pointer overflow wraps
        // the pointer modulo DEPTH.
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state is updated only with non-blocking assignments.
    // All registers then sample their _d values together at the edge,
    // independent of statement order.
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the storage array is reset as well. With every entry cleared,
      // iadder_out and misaligned_out read zero after reset, not stale data.
      // This costs a reset net on each storage bit.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Outputs come only from registered queue state, never straight from inputs.
  assign iadder_out     = mem_q[rd_ptr_q].addr;
  assign misaligned_out = mem_q[rd_ptr_q].misaligned;
  assign count_out      = count_q;

endmodule

// File: tb/tb_msrv32_addr_gen_unit.sv
// ---------------------------------------------------------------------------
// Testbench for msrv32_addr_gen_unit.
// Two instances share one stimulus: one with IALIGN=4 and one with IALIGN=2.
// Expected results come from a queue-based reference model that applies the
// address rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_msrv32_addr_gen_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_in, valid_in, ready_in, flush_in;
  logic            iadder_src_in, jalr_in;
  logic [XLEN-1:0] pc_in, rs_1_in, imm_in;

  logic            ready_out_a, valid_out_a, mis_a;
  logic [XLEN-1:0] addr_a;
  logic [1:0]      count_a;
  logic            ready_out_b, valid_out_b, mis_b;
  logic [XLEN-1:0] addr_b;
  logic [1:0]      count_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [XLEN-1:0] addr;
    bit              m4;
    bit              m2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  msrv32_addr_gen_unit #(.XLEN(XLEN), .IALIGN(4), .DEPTH(DEPTH)) dut_a (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out_a),
    .pc_in(pc_in), .rs_1_in(rs_1_in), .imm_in(imm_in),
    .iadder_src_in(iadder_src_in), .jalr_in(jalr_in),
    .valid_out(valid_out_a), .ready_in(ready_in), .iadder_out(addr_a),
    .misaligned_out(mis_a), .flush_in(flush_in), .count_out(count_a)
  );

  msrv32_addr_gen_unit #(.XLEN(XLEN), .IALIGN(2), .DEPTH(DEPTH)) dut_b (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out_b),
    .pc_in(pc_in), .rs_1_in(rs_1_in), .imm_in(imm_in),
    .iadder_src_in(iadder_src_in), .jalr_in(jalr_in),
    .valid_out(valid_out_b), .ready_in(ready_in), .iadder_out(addr_b),
    .misaligned_out(mis_b), .flush_in(flush_in), .count_out(count_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference target: the sum wraps at 32 bits, and JALR makes it even.
  function automatic exp_t model(input bit src, input logic [XLEN-1:0] pc,
                                 input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm,
                                 input bit jalr);
    exp_t e;
    longint unsigned s;
    s = ((src ? longint'(rs1) : longint'(pc)) + longint'(imm)) % 64'h1_0000_0000;
    if (jalr && (s % 2 == 1)) s = s - 1;
    e.addr = s[XLEN-1:0];
    e.m4   = (s % 4) != 0;
    e.m2   = (s % 2) != 0;
    return e;
  endfunction

  task automatic set_req(input bit src, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm,
                         input bit jalr);
    iadder_src_in = src;
    pc_in         = pc;
    rs_1_in       = rs1;
    imm_in        = imm;
    jalr_in       = jalr;
  endtask

  // Advance one clock. The model is updated from the inputs held across the
  // edge. All outputs are then compared 1 time unit after the edge.
  task automatic cycle();
    bit   m_ready, m_push, m_pop;
    exp_t e;
    m_ready = (q.size() < DEPTH) && !rst_in;
    m_push  = valid_in && m_ready && !flush_in;
    m_pop   = (q.size() != 0) && ready_in && !flush_in;
    e       = model(iadder_src_in, pc_in, rs_1_in, imm_in, jalr_in);
    @(posedge clk);
    #1;
    if (rst_in || flush_in) q.delete();
    else begin
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(e);
    end
    check("valid_a", valid_out_a, q.size() != 0);
    check("count_a", count_a, q.size());
    check("ready_a", ready_out_a, (q.size() < DEPTH) && !rst_in);
    check("valid_b", valid_out_b, q.size() != 0);
    check("count_b", count_b, q.size());
    if (q.size() != 0) begin
      check("addr_a", addr_a, q[0].addr);
      check("mis_a",  mis_a,  q[0].m4);
      check("addr_b", addr_b, q[0].addr);
      check("mis_b",  mis_b,  q[0].m2);
    end
  endtask

  initial begin
    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b0; flush_in = 1'b0;
    set_req(0, '0, '0, '0, 0);

    // Reset state.
    cycle();
    cycle();
    check("rst_addr", addr_a, 0);
    check("rst_mis",  mis_a,  0);
    check("rst_ready_low", ready_out_a, 0);
    #1 rst_in = 1'b0;
    cycle();
    check("ready_after_rst", ready_out_a, 1);

    // Single request with rs1 as the base.
    #1 valid_in = 1'b1; ready_in = 1'b1; set_req(1, 32'h8, 32'h8, 32'h4, 0);
    cycle();
    check("tp_rs1_addr", addr_a, 32'hC);
    check("tp_rs1_mis", mis_a, 0);
    check("tp_rs1_cnt", count_a, 1);
    #1 valid_in = 1'b0;
    cycle();

    // PC as the base.
    #1 valid_in = 1'b1; set_req(0, 32'h88, 32'h6, 32'h4, 0);
    cycle();
    check("tp_pc_addr", addr_a, 32'h8C);
    #1 valid_in = 1'b0;
    cycle();

    // JALR with the misalignment check under both IALIGN values.
    #1 valid_in = 1'b1; set_req(1, 32'h0, 32'h1003, 32'h0, 1);
    cycle();
    check("tp_jalr_addr", addr_a, 32'h1002);
    check("tp_jalr_mis4", mis_a, 1);
    check("tp_jalr_mis2", mis_b, 0);
    #1 valid_in = 1'b0;
    cycle();

    // Address wrap and a negative immediate.
    #1 valid_in = 1'b1; set_req(0, 32'hFFFF_FFFC, 32'h0, 32'h8, 0);
    cycle();
    check("tp_wrap", addr_a, 32'h4);
    #1 set_req(0, 32'h100, 32'h0, 32'hFFFF_FFF8, 0);
    cycle();
    check("tp_neg", addr_a, 32'hF8);
    #1 valid_in = 1'b0;
    cycle();

    // Backpressure: fill the queue, have a push refused, then drain in order.
    #1 ready_in = 1'b0; valid_in = 1'b1; set_req(0, 32'h10, 0, 0, 0);
    cycle();
    #1 set_req(0, 32'h20, 0, 0, 0);
    cycle();
    check("bp_full_cnt", count_a, 2);
    check("bp_full_rdy", ready_out_a, 0);
    #1 set_req(0, 32'h30, 0, 0, 0);
    cycle();
    check("bp_refused_cnt", count_a, 2);
    check("bp_hold_head", addr_a, 32'h10);
    #1 valid_in = 1'b0; ready_in = 1'b1;
    cycle();
    check("bp_second", addr_a, 32'h20);
    cycle();
    check("bp_empty", valid_out_a, 0);

    // Flush with two entries queued and a request arriving in the same cycle.
    #1 ready_in = 1'b0; valid_in = 1'b1; set_req(0, 32'h40, 0, 0, 0);
    cycle();
    #1 set_req(0, 32'h50, 0, 0, 0);
    cycle();
    #1 flush_in = 1'b1; ready_in = 1'b1; set_req(0, 32'h60, 0, 0, 0);
    cycle();
    check("fl_cnt", count_a, 0);
    check("fl_valid", valid_out_a, 0);
    #1 flush_in = 1'b0; valid_in = 1'b0;
    cycle();
    check("fl_dropped", valid_out_a, 0);

    // Reset mid-stream, with the same scenario as the flush above.
    #1 ready_in = 1'b0; valid_in = 1'b1; set_req(0, 32'h70, 0, 0, 0);
    cycle();
    #1 set_req(0, 32'h80, 0, 0, 0);
    cycle();
    #1 rst_in = 1'b1; set_req(0, 32'h90, 0, 0, 0);
    cycle();
    check("rs_cnt", count_a, 0);
    check("rs_valid", valid_out_a, 0);
    check("rs_addr", addr_a, 0);
    check("rs_ready", ready_out_a, 0);
    #1 rst_in = 1'b0; valid_in = 1'b0;
    cycle();
    check("rs_ready_rel", ready_out_a, 1);
    check("rs_dropped", valid_out_a, 0);

    // Randomized traffic with occasional flushes and resets.
    for (int n = 0; n < 400; n++) begin
      #1;
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 2) != 0);
      flush_in = ($urandom_range(0, 19) == 0);
      rst_in   = ($urandom_range(0, 49) == 0);
      set_req($urandom_range(0, 1), $urandom, $urandom,
              ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15)),
              $urandom_range(0, 1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_addr_gen_unit.md
Name: msrv32_addr_gen_unit

Overview:
Parametrised, registered successor to the combinational immediate adder. Computes branch/jump/load-store target = base + immediate.
- base is selected between pc_in and rs_1_in.
- Optional JALR bit-0 clear and an instruction-misalignment flag.
- Results are buffered in a DEPTH-entry output queue with valid/ready handshakes on both sides plus a flush.
- Sits between decode/register-read and the PC-mux / load-store unit.

Parameters:
XLEN, 32, datapath width of pc_in, rs_1_in, imm_in, iadder_out (legal: 32, 64)
IALIGN, 4, instruction alignment in bytes for the misalign check (legal: 2, 4)
DEPTH, 2, output queue entries (power of 2, >= 2)

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  synchronous active-high reset
valid_in  input  1  request valid
ready_out  output  1  unit can accept a request this cycle
pc_in  input  XLEN  program counter base
rs_1_in  input  XLEN  register base
imm_in  input  XLEN  sign-extended immediate
iadder_src_in  input  1  1 = base rs_1_in, 0 = base pc_in
jalr_in  input  1  1 = clear bit 0 of the sum (JALR)
valid_out  output  1  head-of-queue result valid
ready_in  input  1  consumer accepts head this cycle
iadder_out  output  XLEN  head result address
misaligned_out  output  1  head result misaligned w.r.t. IALIGN
flush_in  input  1  discard all queued and incoming requests
count_out  output  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- push = valid_in && ready_out && !flush_in.
- pop = valid_out && ready_in && !flush_in.
- Sum = (iadder_src_in ? rs_1_in : pc_in) + imm_in, modulo 2^XLEN. Carry is discarded; no overflow flag.
- If jalr_in = 1, result = {sum[XLEN-1:1], 1'b0}; otherwise result = sum.
- misaligned = OR of result[log2(IALIGN)-1:0], computed after the JALR clear.
  - IALIGN=4: flag = result[1] | result[0].
  - IALIGN=2: flag = result[0], so a JALR result is never flagged.
- Latency: a request pushed in cycle N is visible on valid_out/iadder_out/misaligned_out in cycle N+1 when the queue was empty. Otherwise it appears in FIFO order behind older entries.
- Outputs are driven from the queue head only. They are never a combinational path from the inputs.
- ready_out = (count < DEPTH) && !rst_in. When full, push is refused even if a pop occurs in the same cycle. There is no same-cycle full bypass.
- valid_out = (count != 0).
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, the head advances and the new entry is written at the tail.
- Push and pop with count = 0 is impossible, because valid_out = 0.
- Pointers wrap modulo DEPTH.
- flush_in = 1 (highest priority after reset):
  - next cycle count = 0, valid_out = 0, pointers = 0;
  - the same-cycle valid_in request is dropped and ready_in is ignored.
- Holding rule: while valid_out = 1 and ready_in = 0, iadder_out and misaligned_out hold stable.
- Reset (rst_in = 1 at an edge):
  - count_out = 0, valid_out = 0, iadder_out = 0, misaligned_out = 0, all storage cleared;
  - ready_out = 0 while rst_in is high, 1 from the first cycle after release.
  - Reset mid-operation discards all queued entries, same as flush.
- Input values are sampled only at push; inputs in non-push cycles are don't-care.

Test Plan:
- Single request, rs1 base: reset, then src=1, pc=0x8, rs1=0x8, imm=0x4, jalr=0, ready_in=1 -> next cycle valid_out=1, iadder_out=0xC, misaligned_out=0, count_out=1.
- PC base: src=0, pc=0x88, rs1=0x6, imm=0x4 -> iadder_out=0x8C, misaligned_out=0.
- JALR and misalignment:
  - src=1, rs1=0x1003, imm=0x0, jalr=1, IALIGN=4 -> iadder_out=0x1002, misaligned_out=1.
  - Same with IALIGN=2 -> misaligned_out=0.
- Wrap and negative immediate:
  - src=0, pc=0xFFFFFFFC, imm=0x8 -> iadder_out=0x00000004.
  - pc=0x100, imm=0xFFFFFFF8 (-8) -> 0xF8.
- Backpressure/full, DEPTH=2, ready_in=0:
  - push 0x10, then 0x20 -> count_out=2, ready_out=0.
  - a third valid_in is refused, and the head holds 0x10.
  - raise ready_in -> outputs 0x10, then 0x20 in order, then valid_out=0.
- Flush and reset mid-stream:
  - with 2 entries queued, assert flush_in together with valid_in -> next cycle count_out=0, valid_out=0, dropped request never appears.
  - repeat with rst_in instead -> same, plus iadder_out=0 and ready_out=0 during reset.
